ps2_cmd_sequencer: RTL and testbench



---
 rtl/ps2_pkg.sv | 63 ++++++
 rtl/ps2_req_arbiter.sv | 45 ++++
 rtl/ps2_cmd_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_ps2_cmd_sequencer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-to-keyboard command path.
// Contents: command/response byte codes, sequencer state encodings,
// requester IDs, abort codes and the latched command payload.
package ps2_pkg;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned TIMER_W = 26;
    localparam int unsigned RETRY_W = 8;

    localparam logic [7:0] CMD_RESET     = 8'hFF;
    localparam logic [7:0] CMD_SET_LED   = 8'hED;
    localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;
    localparam logic [7:0] RSP_ACK       = 8'hFA;
    localparam logic [7:0] RSP_RESEND    = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK    = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL  = 8'hFC;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEND      = 3'd1;
    localparam logic [2:0] ST_WAIT_SENT = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd3;
    localparam logic [2:0] ST_WAIT_BAT  = 3'd4;
    localparam logic [2:0] ST_FINISH    = 3'd5;

    localparam logic [ID_W-1:0] ID_RESET     = 2'd0;
    localparam logic [ID_W-1:0] ID_LED       = 2'd1;
    localparam logic [ID_W-1:0] ID_TYPEMATIC = 2'd2;

    localparam logic [1:0] ERR_NONE        = 2'd0;
    localparam logic [1:0] ERR_RETRY       = 2'd1;
    localparam logic [1:0] ERR_BAT_FAIL    = 2'd2;
    localparam logic [1:0] ERR_BAT_TIMEOUT = 2'd3;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [7:0]      byte0;
        logic [7:0]      byte1;
    } cmd_t;

    // Command bytes for a requester; byte1 is unused by the reset command.
    function automatic cmd_t build_cmd(input logic [ID_W-1:0] id,
                                       input logic [2:0]      led,
                                       input logic [7:0]      rate);
        cmd_t c;
        c.id    = id;
        c.byte0 = CMD_RESET;
        c.byte1 = 8'h00;
        case (id)
            ID_LED: begin
                c.byte0 = CMD_SET_LED;
                c.byte1 = {5'b0, led};
            end
            ID_TYPEMATIC: begin
                c.byte0 = CMD_TYPEMATIC;
                c.byte1 = rate;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ps2_req_arbiter.sv
// Pending-request register with fixed-priority grant (0 > 1 > 2).
// Ports: req pulses set pend bits; gnt_en allows a grant this cycle;
// gnt_valid_c/gnt_id_c give the combinational grant. The granted bit is
// cleared, and a pulse in the same cycle re-sets it.
module ps2_req_arbiter
    import ps2_pkg::*;
(
    input  logic                 inclock,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 gnt_en,
    output logic                 gnt_valid_c,
    output logic [ID_W-1:0]      gnt_id_c
);

    logic [NUM_REQ-1:0] pend_q;
    logic [NUM_REQ-1:0] pend_d;
    logic [NUM_REQ-1:0] gnt_mask;

    // Priority select and pend update.
    always_comb begin
        gnt_mask = '0;
        gnt_id_c = ID_RESET;
        if (gnt_en) begin
            if (pend_q[0]) begin
                gnt_mask = 3'b001;
                gnt_id_c = ID_RESET;
            end else if (pend_q[1]) begin
                gnt_mask = 3'b010;
                gnt_id_c = ID_LED;
            end else if (pend_q[2]) begin
                gnt_mask = 3'b100;
                gnt_id_c = ID_TYPEMATIC;
            end
        end
        gnt_valid_c = |gnt_mask;
        pend_d      = (pend_q & ~gnt_mask) | req;
    end

    always_ff @(posedge inclock) begin
        if (!resetn) pend_q <= '0;
        else         pend_q <= pend_d;
    end

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// Host-to-keyboard command sequencer: arbitrates reset/LED/typematic
// requests, sends command bytes, handles ACK/RESEND/BAT with retry and
// timeouts, and forwards every unconsumed received byte.
// Ports: req/led_value/typematic_value (requesters); the_command,
// send_command, command_was_sent, error_communication_timed_out,
// received_data(_en) (PS2_Controller); key_data(_en) (forwarded bytes);
// busy, done, done_id, error, err_code (status).
module ps2_cmd_sequencer
    import ps2_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 1_000_000,
    parameter int unsigned BAT_TIMEOUT = 50_000_000,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic             inclock,
    input  logic             resetn,
    input  logic [2:0]       req,
    input  logic [2:0]       led_value,
    input  logic [7:0]       typematic_value,
    output logic [7:0]       the_command,
    output logic             send_command,
    input  logic             command_was_sent,
    input  logic             error_communication_timed_out,
    input  logic [7:0]       received_data,
    input  logic             received_data_en,
    output logic [7:0]       key_data,
    output logic             key_data_en,
    output logic             busy,
    output logic             done,
    output logic [ID_W-1:0]  done_id,
    output logic             error,
    output logic [1:0]       err_code
);

    localparam logic [TIMER_W-1:0] ACK_LIMIT = TIMER_W'(ACK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] BAT_LIMIT = TIMER_W'(BAT_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    logic [2:0]         state_q,    state_d;
    cmd_t               cmd_q,      cmd_d;
    logic               idx_q,      idx_d;
    logic [RETRY_W-1:0] retry_q,    retry_d;
    logic [TIMER_W-1:0] timer_q,    timer_d;
    logic [7:0]         the_command_q, the_command_d;
    logic               send_command_q, send_command_d;
    logic [7:0]         key_data_q, key_data_d;
    logic               key_data_en_q, key_data_en_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic [ID_W-1:0]    done_id_q,  done_id_d;
    logic               error_q,    error_d;
    logic [1:0]         err_code_q, err_code_d;

    logic               gnt_en_c;
    logic               gnt_valid_c;
    logic [ID_W-1:0]    gnt_id_c;
    logic               ack_expired_c;
    logic               bat_expired_c;
    logic               do_retry;
    logic               consume;
    logic               fin_err;
    logic [1:0]         fin_code;

    assign gnt_en_c = (state_q == ST_IDLE);

    ps2_req_arbiter u_arb (
        .inclock     (inclock),
        .resetn      (resetn),
        .req         (req),
        .gnt_en      (gnt_en_c),
        .gnt_valid_c (gnt_valid_c),
        .gnt_id_c    (gnt_id_c)
    );

    // >= rather than == so an expiry masked by a coincident byte still fires.
    assign ack_expired_c = (timer_q >= ACK_LIMIT);
    assign bat_expired_c = (timer_q >= BAT_LIMIT);

    // Next-state, retry and response handling.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        idx_d    = idx_q;
        retry_d  = retry_q;
        do_retry = 1'b0;
        consume  = 1'b0;
        fin_err  = 1'b0;
        fin_code = ERR_NONE;

        case (state_q)
            ST_IDLE: begin
                if (gnt_valid_c) begin
                    cmd_d   = build_cmd(gnt_id_c, led_value, typematic_value);
                    idx_d   = 1'b0;
                    retry_d = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: state_d = ST_WAIT_SENT;
            ST_WAIT_SENT: begin
                if (command_was_sent)                                   state_d  = ST_WAIT_ACK;
                else if (error_communication_timed_out || ack_expired_c) do_retry = 1'b1;
            end
            ST_WAIT_ACK: begin
                if (received_data_en) begin
                    if (received_data == RSP_ACK) begin
                        consume = 1'b1;
                        if (cmd_q.id == ID_RESET) begin
                            state_d = ST_WAIT_BAT;
                        end else if (!idx_q) begin
                            idx_d   = 1'b1;
                            retry_d = '0;
                            state_d = ST_SEND;
                        end else begin
                            state_d = ST_FINISH;
                        end
                    end else if (received_data == RSP_RESEND) begin
                        consume  = 1'b1;
                        do_retry = 1'b1;
                    end
                end else if (ack_expired_c) begin
                    do_retry = 1'b1;
                end
            end
            ST_WAIT_BAT: begin
                if (received_data_en) begin
                    if (received_data == RSP_BAT_OK) begin
                        consume = 1'b1;
                        state_d = ST_FINISH;
                    end else if (received_data == RSP_BAT_FAIL) begin
                        consume  = 1'b1;
                        fin_err  = 1'b1;
                        fin_code = ERR_BAT_FAIL;
                        state_d  = ST_FINISH;
                    end
                end else if (bat_expired_c) begin
                    fin_err  = 1'b1;
                    fin_code = ERR_BAT_TIMEOUT;
                    state_d  = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (do_retry) begin
            if (retry_q == RETRY_MAX) begin
                fin_err  = 1'b1;
                fin_code = ERR_RETRY;
                state_d  = ST_FINISH;
            end else begin
                retry_d = retry_q + RETRY_W'(1);
                state_d = ST_SEND;
            end
        end
    end

    // Registered outputs decoded from the next state; timer cleared on
    // entry to SEND and WAIT_BAT, otherwise saturating count.
    always_comb begin
        the_command_d  = the_command_q;
        send_command_d = (state_d == ST_SEND);
        busy_d         = (state_d != ST_IDLE);
        done_d         = (state_d == ST_FINISH);
        done_id_d      = '0;
        error_d        = 1'b0;
        err_code_d     = ERR_NONE;
        key_data_d     = key_data_q;
        key_data_en_d  = 1'b0;
        timer_d        = timer_q;

        if (state_d == ST_SEND) the_command_d = idx_d ? cmd_d.byte1 : cmd_d.byte0;
        if (done_d) begin
            done_id_d  = cmd_d.id;
            error_d    = fin_err;
            err_code_d = fin_code;
        end
        if (received_data_en && !consume) begin
            key_data_d    = received_data;
            key_data_en_d = 1'b1;
        end

        if ((state_d == ST_SEND) || (state_d == ST_WAIT_BAT && state_q != ST_WAIT_BAT))
            timer_d = '0;
        else if (timer_q != '1)
            timer_d = timer_q + TIMER_W'(1);
    end

    always_ff @(posedge inclock) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            cmd_q          <= '0;
            idx_q          <= 1'b0;
            retry_q        <= '0;
            timer_q        <= '0;
            the_command_q  <= 8'h00;
            send_command_q <= 1'b0;
            key_data_q     <= 8'h00;
            key_data_en_q  <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            done_id_q      <= '0;
            error_q        <= 1'b0;
            err_code_q     <= ERR_NONE;
        end else begin
            state_q        <= state_d;
            cmd_q          <= cmd_d;
            idx_q          <= idx_d;
            retry_q        <= retry_d;
            timer_q        <= timer_d;
            the_command_q  <= the_command_d;
            send_command_q <= send_command_d;
            key_data_q     <= key_data_d;
            key_data_en_q  <= key_data_en_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            done_id_q      <= done_id_d;
            error_q        <= error_d;
            err_code_q     <= err_code_d;
        end
    end

    assign the_command  = the_command_q;
    assign send_command = send_command_q;
    assign key_data     = key_data_q;
    assign key_data_en  = key_data_en_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign done_id      = done_id_q;
    assign error        = error_q;
    assign err_code     = err_code_q;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Directed bench for ps2_cmd_sequencer with a scripted controller/keyboard.
module tb_ps2_cmd_sequencer;
    import ps2_pkg::*;

    localparam int unsigned ACK_TO = 100;
    localparam int unsigned BAT_TO = 2000;

    logic       inclock = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] req = 3'b000;
    logic [2:0] led_value = 3'b000;
    logic [7:0] typematic_value = 8'h00;
    logic       command_was_sent = 1'b0;
    logic       error_communication_timed_out = 1'b0;
    logic [7:0] received_data = 8'h00;
    logic       received_data_en = 1'b0;
    logic [7:0] the_command;
    logic       send_command;
    logic [7:0] key_data;
    logic       key_data_en;
    logic       busy;
    logic       done;
    logic [1:0] done_id;
    logic       error;
    logic [1:0] err_code;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] sent_q[$];
    logic [1:0] done_ids[$];
    int         n_fwd  = 0;
    int         n_done = 0;

    always #5 inclock = ~inclock;

    ps2_cmd_sequencer #(
        .ACK_TIMEOUT (ACK_TO),
        .BAT_TIMEOUT (BAT_TO),
        .MAX_RETRY   (3)
    ) dut (
        .inclock                       (inclock),
        .resetn                        (resetn),
        .req                           (req),
        .led_value                     (led_value),
        .typematic_value               (typematic_value),
        .the_command                   (the_command),
        .send_command                  (send_command),
        .command_was_sent              (command_was_sent),
        .error_communication_timed_out (error_communication_timed_out),
        .received_data                 (received_data),
        .received_data_en              (received_data_en),
        .key_data                      (key_data),
        .key_data_en                   (key_data_en),
        .busy                          (busy),
        .done                          (done),
        .done_id                       (done_id),
        .error                         (error),
        .err_code                      (err_code)
    );

    // Logs of transmitted bytes, forwarded bytes and completions.
    always @(posedge inclock) begin
        if (send_command) sent_q.push_back(the_command);
        if (key_data_en) n_fwd = n_fwd + 1;
        if (done) begin
            n_done = n_done + 1;
            done_ids.push_back(done_id);
        end
    end

    task automatic tick();
        @(posedge inclock);
        #1;
    endtask

    task automatic pulse_req(input logic [2:0] r);
        req = r;
        tick();
        req = 3'b000;
    endtask

    task automatic wait_strobe(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= budget; i++) begin
            if (send_command) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= budget; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Controller reports the byte clocked out; leaves DUT in WAIT_ACK.
    task automatic host_sent();
        tick();
        command_was_sent = 1'b1;
        tick();
        command_was_sent = 1'b0;
        tick();
    endtask

    task automatic rx_byte(input logic [7:0] b);
        received_data    = b;
        received_data_en = 1'b1;
        tick();
        received_data_en = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) tick();
        n_vec++;
        if ({the_command, send_command, busy, done, done_id, error, err_code, key_data, key_data_en} !== 25'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h required 0",
                     {the_command, send_command, busy, done, done_id, error, err_code, key_data, key_data_en});
        end
        resetn = 1'b1;
        repeat (3) tick();
        n_vec++;
        if ({busy, send_command} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_idle: busy/strobe got %b required 00", {busy, send_command});
        end
    endtask

    task automatic test_forward_idle();
        rx_byte(8'h55);
        n_vec++;
        if (key_data_en !== 1'b1 || key_data !== 8'h55) begin
            n_err++;
            $display("FAIL fwd_idle: en=%b data=%h required 1/55", key_data_en, key_data);
        end
        tick();
        n_vec++;
        if (key_data_en !== 1'b0) begin
            n_err++;
            $display("FAIL fwd_idle_pulse: en=%b required 0", key_data_en);
        end
    endtask

    task automatic test_led();
        int s0, f0;
        bit ok;
        s0 = sent_q.size();
        f0 = n_fwd;
        led_value = 3'b101;
        pulse_req(3'b010);
        n_vec++;
        if (send_command !== 1'b0) begin
            n_err++;
            $display("FAIL led_latency_early: strobe=%b required 0", send_command);
        end
        tick();
        n_vec++;
        if (send_command !== 1'b1 || the_command !== 8'hED || busy !== 1'b1) begin
            n_err++;
            $display("FAIL led_first_byte: strobe=%b cmd=%h busy=%b required 1/ED/1", send_command, the_command, busy);
        end
        host_sent();
        n_vec++;
        if (the_command !== 8'hED || send_command !== 1'b0) begin
            n_err++;
            $display("FAIL led_hold: cmd=%h strobe=%b required ED/0", the_command, send_command);
        end
        rx_byte(RSP_ACK);
        wait_strobe(10, ok);
        n_vec++;
        if (!ok || the_command !== 8'h05) begin
            n_err++;
            $display("FAIL led_second_byte: ok=%b cmd=%h required 1/05", ok, the_command);
        end
        host_sent();
        rx_byte(RSP_ACK);
        wait_done(10, ok);
        n_vec++;
        if (!ok || done_id !== ID_LED || error !== 1'b0 || err_code !== ERR_NONE) begin
            n_err++;
            $display("FAIL led_done: ok=%b id=%0d err=%b code=%0d required 1/1/0/0", ok, done_id, error, err_code);
        end
        tick();
        tick();
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || n_fwd !== f0 || sent_q.size() !== s0 + 2) begin
            n_err++;
            $display("FAIL led_after: done=%b busy=%b fwd=%0d sent=%0d required 0/0/%0d/%0d",
                     done, busy, n_fwd, sent_q.size(), f0, s0 + 2);
        end
    endtask

    task automatic test_reset_cmd(input logic [7:0] bat, input logic exp_err, input logic [1:0] exp_code);
        int f0;
        bit ok;
        f0 = n_fwd;
        pulse_req(3'b001);
        wait_strobe(10, ok);
        n_vec++;
        if (!ok || the_command !== CMD_RESET) begin
            n_err++;
            $display("FAIL rst_cmd_byte: ok=%b cmd=%h required 1/FF", ok, the_command);
        end
        host_sent();
        rx_byte(RSP_ACK);
        if (bat != 8'h00) begin
            repeat (1000) tick();
            n_vec++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL rst_wait_bat: busy=%b done=%b required 1/0", busy, done);
            end
            rx_byte(bat);
            wait_done(5, ok);
        end else begin
            wait_done(BAT_TO + 50, ok);
        end
        n_vec++;
        if (!ok || done_id !== ID_RESET || error !== exp_err || err_code !== exp_code) begin
            n_err++;
            $display("FAIL rst_done_%h: ok=%b id=%0d err=%b code=%0d required 1/0/%b/%0d",
                     bat, ok, done_id, error, err_code, exp_err, exp_code);
        end
        tick();
        n_vec++;
        if (n_fwd !== f0) begin
            n_err++;
            $display("FAIL rst_no_fwd_%h: fwd=%0d required %0d", bat, n_fwd, f0);
        end
    endtask

    task automatic test_typematic();
        int s0;
        bit ok;
        logic [7:0] exp_seq [4];
        exp_seq = '{8'hF3, 8'hF3, 8'hF3, 8'h2B};
        s0 = sent_q.size();
        typematic_value = 8'h2B;
        pulse_req(3'b100);
        for (int k = 0; k < 3; k++) begin
            wait_strobe(10, ok);
            host_sent();
            rx_byte(k < 2 ? RSP_RESEND : RSP_ACK);
        end
        wait_strobe(10, ok);
        host_sent();
        rx_byte(RSP_ACK);
        wait_done(10, ok);
        n_vec++;
        if (!ok || done_id !== ID_TYPEMATIC || error !== 1'b0) begin
            n_err++;
            $display("FAIL tm_done: ok=%b id=%0d err=%b required 1/2/0", ok, done_id, error);
        end
        tick();
        n_vec++;
        if (sent_q.size() !== s0 + 4) begin
            n_err++;
            $display("FAIL tm_count: sent=%0d required %0d", sent_q.size() - s0, 4);
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_vec++;
                if (sent_q[s0 + k] !== exp_seq[k]) begin
                    n_err++;
                    $display("FAIL tm_byte%0d: got %h required %h", k, sent_q[s0 + k], exp_seq[k]);
                end
            end
        end
    endtask

    task automatic test_no_ack();
        int s0;
        bit ok;
        s0 = sent_q.size();
        typematic_value = 8'h11;
        pulse_req(3'b100);
        for (int k = 0; k < 4; k++) begin
            wait_strobe(2 * ACK_TO, ok);
            n_vec++;
            if (!ok || the_command !== CMD_TYPEMATIC) begin
                n_err++;
                $display("FAIL noack_send%0d: ok=%b cmd=%h required 1/F3", k, ok, the_command);
            end
            host_sent();
        end
        wait_done(2 * ACK_TO, ok);
        n_vec++;
        if (!ok || error !== 1'b1 || err_code !== ERR_RETRY || done_id !== ID_TYPEMATIC) begin
            n_err++;
            $display("FAIL noack_abort: ok=%b err=%b code=%0d id=%0d required 1/1/1/2", ok, error, err_code, done_id);
        end
        repeat (3) tick();
        n_vec++;
        if (sent_q.size() !== s0 + 4 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL noack_sends: sent=%0d busy=%b required 4/0", sent_q.size() - s0, busy);
        end
    endtask

    // One complete two-byte command with ACKs; returns with done visible.
    task automatic serve_two_byte(input logic [7:0] b0, input logic [7:0] b1, input logic extra_led);
        bit ok;
        wait_strobe(10, ok);
        n_vec++;
        if (!ok || the_command !== b0) begin
            n_err++;
            $display("FAIL prio_byte0: ok=%b cmd=%h required 1/%h", ok, the_command, b0);
        end
        if (extra_led) pulse_req(3'b010);
        host_sent();
        rx_byte(RSP_ACK);
        wait_strobe(10, ok);
        host_sent();
        rx_byte(RSP_ACK);
        wait_done(10, ok);
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_ids.size();
        led_value = 3'b010;
        typematic_value = 8'h33;
        pulse_req(3'b110);
        serve_two_byte(CMD_SET_LED, 8'h02, 1'b0);
        serve_two_byte(CMD_TYPEMATIC, 8'h33, 1'b1);
        serve_two_byte(CMD_SET_LED, 8'h02, 1'b0);
        tick();
        n_vec++;
        if (done_ids.size() !== d0 + 3) begin
            n_err++;
            $display("FAIL prio_count: dones=%0d required 3", done_ids.size() - d0);
        end else begin
            n_vec++;
            if ({done_ids[d0], done_ids[d0 + 1], done_ids[d0 + 2]} !== {ID_LED, ID_TYPEMATIC, ID_LED}) begin
                n_err++;
                $display("FAIL prio_order: got %0d,%0d,%0d required 1,2,1",
                         done_ids[d0], done_ids[d0 + 1], done_ids[d0 + 2]);
            end
        end
    endtask

    task automatic test_fwd_and_reset();
        int f0, d0, s0;
        bit ok;
        led_value = 3'b001;
        pulse_req(3'b010);
        wait_strobe(10, ok);
        host_sent();
        f0 = n_fwd;
        received_data    = 8'h1C;
        received_data_en = 1'b1;
        tick();
        received_data_en = 1'b0;
        n_vec++;
        if (key_data_en !== 1'b1 || key_data !== 8'h1C || the_command !== CMD_SET_LED) begin
            n_err++;
            $display("FAIL fwd_1c: en=%b data=%h cmd=%h required 1/1C/ED", key_data_en, key_data, the_command);
        end
        rx_byte(RSP_ACK);
        n_vec++;
        if (key_data_en !== 1'b0 || n_fwd !== f0 + 1) begin
            n_err++;
            $display("FAIL fwd_fa_consumed: en=%b fwd=%0d required 0/%0d", key_data_en, n_fwd, f0 + 1);
        end
        wait_strobe(10, ok);
        host_sent();
        d0 = n_done;
        resetn = 1'b0;
        tick();
        tick();
        s0 = sent_q.size();
        n_vec++;
        if ({the_command, send_command, busy, done, done_id, error, err_code, key_data, key_data_en} !== 25'd0) begin
            n_err++;
            $display("FAIL midcmd_reset: got %h required 0",
                     {the_command, send_command, busy, done, done_id, error, err_code, key_data, key_data_en});
        end
        resetn = 1'b1;
        repeat (20) tick();
        n_vec++;
        if (n_done !== d0 || busy !== 1'b0 || sent_q.size() !== s0) begin
            n_err++;
            $display("FAIL midcmd_quiet: dones=%0d busy=%b sends=%0d required 0/0/0",
                     n_done - d0, busy, sent_q.size() - s0);
        end
    endtask

    initial begin
        test_reset();
        test_forward_idle();
        test_led();
        test_reset_cmd(RSP_BAT_OK,   1'b0, ERR_NONE);
        test_reset_cmd(RSP_BAT_FAIL, 1'b1, ERR_BAT_FAIL);
        test_reset_cmd(8'h00,        1'b1, ERR_BAT_TIMEOUT);
        test_typematic();
        test_no_ack();
        test_back_to_back();
        test_fwd_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
